// File: rtl/vga_timing_out.sv
// rtl/vga_timing_out.sv - progressive VGA raster, composer pacing strobes and aligned pixel output stage
module vga_timing_out #(
    parameter int CLK_DIV      = 2,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit HSYNC_POL    = 1'b0,
    parameter bit VSYNC_POL    = 1'b0,
    parameter int DATA_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       display_next_frame,
    output logic       display_next_line,
    output logic       display_next_pixel,
    output logic       display_current_field,
    input  logic [7:0] display_data,
    output logic [7:0] vga_data,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_active
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Pipeline entry layout: {strobe, hs, vs, act}
    localparam int P_STB = 3;
    localparam int P_HS  = 2;
    localparam int P_VS  = 1;
    localparam int P_ACT = 0;

    logic [2:0] div_cnt_q;
    logic [9:0] h_cnt_q;
    logic [9:0] v_cnt_q;
    logic       next_pixel_q;
    logic       next_line_q;
    logic       next_frame_q;
    logic [3:0] pipe_q [0:DATA_LATENCY];
    logic [7:0] vga_data_q;
    logic       vga_active_q;
    logic       vga_hsync_q;
    logic       vga_vsync_q;

    logic       run;
    logic       pix_stb;
    logic       hs_d;
    logic       vs_d;
    logic       act_d;
    logic       line_end_d;
    logic [3:0] out_tap;

    // Raster decode from the pre-increment counters
    always_comb begin
        run        = enable && !rst;
        pix_stb    = enable && (div_cnt_q == DIV_LAST);
        hs_d       = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        vs_d       = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
        act_d      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        line_end_d = (h_cnt_q == H_LAST);
        out_tap    = pipe_q[DATA_LATENCY];
    end

    // Pixel divider and h/v counters; held at origin while stopped
    always_ff @(posedge clk) begin
        if (!run) begin
            div_cnt_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
        end else begin
            div_cnt_q <= pix_stb ? 3'd0 : div_cnt_q + 3'd1;
            if (pix_stb) begin
                if (line_end_d) begin
                    h_cnt_q <= '0;
                    v_cnt_q <= (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
                end else begin
                    h_cnt_q <= h_cnt_q + 10'd1;
                end
            end
        end
    end

    // One-clock composer pacing strobes, registered the clock after pix_stb
    always_ff @(posedge clk) begin
        if (!run) begin
            next_pixel_q <= 1'b0;
            next_line_q  <= 1'b0;
            next_frame_q <= 1'b0;
        end else begin
            next_pixel_q <= pix_stb && (h_cnt_q < H_ACT);
            next_line_q  <= pix_stb && line_end_d;
            next_frame_q <= pix_stb && line_end_d && (v_cnt_q == V_LAST);
        end
    end

    // Decode carried alongside the strobes, then delayed to meet display_data
    always_ff @(posedge clk) begin
        if (!run) begin
            for (int i = 0; i <= DATA_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= {pix_stb, hs_d, vs_d, act_d};
            for (int i = 1; i <= DATA_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Output stage: data, active and syncs update together on the delayed strobe
    always_ff @(posedge clk) begin
        if (!run) begin
            vga_data_q   <= '0;
            vga_active_q <= 1'b0;
            vga_hsync_q  <= !HSYNC_POL;
            vga_vsync_q  <= !VSYNC_POL;
        end else if (out_tap[P_STB]) begin
            vga_data_q   <= out_tap[P_ACT] ? display_data : 8'd0;
            vga_active_q <= out_tap[P_ACT];
            vga_hsync_q  <= out_tap[P_HS] ? HSYNC_POL : !HSYNC_POL;
            vga_vsync_q  <= out_tap[P_VS] ? VSYNC_POL : !VSYNC_POL;
        end
    end

    assign display_next_pixel    = next_pixel_q;
    assign display_next_line     = next_line_q;
    assign display_next_frame    = next_frame_q;
    assign display_current_field = 1'b0;
    assign vga_data              = vga_data_q;
    assign vga_active            = vga_active_q;
    assign vga_hsync             = vga_hsync_q;
    assign vga_vsync             = vga_vsync_q;

endmodule
